// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : decode_stage
// Purpose : Instruction decode, load-use hazard detection and ID/EX register.
// Revision: 1.0 - initial release
// ============================================================================

package Defs;
    typedef enum logic [2:0] {
        AND_OP = 3'd0,
        XOR_OP = 3'd1,
        SHL_OP = 3'd2,
        SHR_OP = 3'd3,
        ADD_OP = 3'd4,
        LW_OP  = 3'd5,
        SW_OP  = 3'd6,
        BR_OP  = 3'd7
    } opcode_t;

    typedef struct packed {
        logic    regWrite;
        logic    memRead;
        logic    memWrite;
        logic    MemToReg;
        logic    branch;
        logic    incrementPage;
        logic    decrementPage;
        opcode_t OP;
    } ControlSignals;
endpackage

module decode_stage #(
    parameter int PCW = 8,
    parameter int RAW = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_valid,
    input  logic [8:0]          if_instr,
    input  logic [PCW-1:0]      if_pc,
    input  logic                flush,
    input  logic                ex_hold,
    output logic                stall_o,
    output logic                ex_valid,
    output Defs::ControlSignals ex_ctrl,
    output logic [RAW-1:0]      ex_ra,
    output logic [RAW-1:0]      ex_rb,
    output logic [PCW-1:0]      ex_pc
);
    import Defs::*;

    localparam logic [2:0] C_PAGE_RA = 3'b111;

    opcode_t        w_opc;
    logic [2:0]     w_ra;
    logic [2:0]     w_rb;
    ControlSignals  w_ctrl;
    logic           w_pageop;
    logic           w_hz;

    logic           ex_valid_d, ex_valid_q;
    ControlSignals  ex_ctrl_d,  ex_ctrl_q;
    logic [RAW-1:0] ex_ra_d,    ex_ra_q;
    logic [RAW-1:0] ex_rb_d,    ex_rb_q;
    logic [PCW-1:0] ex_pc_d,    ex_pc_q;

    assign w_opc = opcode_t'(if_instr[8:6]);
    assign w_ra  = if_instr[5:3];
    assign w_rb  = if_instr[2:0];

    always_comb begin
        w_ctrl   = '0;
        w_pageop = 1'b0;
        case (w_opc)
            AND_OP, XOR_OP, SHL_OP, SHR_OP, ADD_OP: begin
                w_ctrl.regWrite = 1'b1;
                w_ctrl.OP       = w_opc;
            end
            LW_OP: begin
                w_ctrl.regWrite = 1'b1;
                w_ctrl.memRead  = 1'b1;
                w_ctrl.MemToReg = 1'b1;
                w_ctrl.OP       = LW_OP;
            end
            SW_OP: begin
                w_ctrl.memWrite = 1'b1;
                w_ctrl.OP       = SW_OP;
            end
            BR_OP: begin
                w_ctrl.OP = BR_OP;
                // rA of all ones turns a branch into a page op that reads no registers
                if (w_ra == C_PAGE_RA) begin
                    w_pageop = 1'b1;
                    if (w_rb[0]) w_ctrl.decrementPage = 1'b1;
                    else         w_ctrl.incrementPage = 1'b1;
                end else begin
                    w_ctrl.branch = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_hz = ex_valid_q & ex_ctrl_q.memRead & if_valid & ~w_pageop &
                  ((ex_ra_q == RAW'(w_ra)) | (ex_ra_q == RAW'(w_rb)));

    assign stall_o = ~flush & (ex_hold | w_hz);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_ra_d    = ex_ra_q;
        ex_rb_d    = ex_rb_q;
        ex_pc_d    = ex_pc_q;
        if (flush || (!ex_hold && (w_hz || !if_valid))) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_ra_d    = '0;
            ex_rb_d    = '0;
            ex_pc_d    = '0;
        end else if (!ex_hold) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = w_ctrl;
            ex_ra_d    = RAW'(w_ra);
            ex_rb_d    = RAW'(w_rb);
            ex_pc_d    = if_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_ra_q    <= '0;
            ex_rb_q    <= '0;
            ex_pc_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_ra_q    <= ex_ra_d;
            ex_rb_q    <= ex_rb_d;
            ex_pc_q    <= ex_pc_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_ra    = ex_ra_q;
    assign ex_rb    = ex_rb_q;
    assign ex_pc    = ex_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_stage
// Purpose : Directed vector bench for decode_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                if_valid;
    logic [8:0]          if_instr;
    logic [7:0]          if_pc;
    logic                flush;
    logic                ex_hold;
    logic                stall_o;
    logic                ex_valid;
    Defs::ControlSignals ex_ctrl;
    logic [2:0]          ex_ra;
    logic [2:0]          ex_rb;
    logic [7:0]          ex_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    // {regWrite, memRead, memWrite, MemToReg, branch, incPage, decPage, OP[2:0]}
    localparam logic [9:0] C_AND = 10'b1000000_000;
    localparam logic [9:0] C_XOR = 10'b1000000_001;
    localparam logic [9:0] C_SHL = 10'b1000000_010;
    localparam logic [9:0] C_SHR = 10'b1000000_011;
    localparam logic [9:0] C_ADD = 10'b1000000_100;
    localparam logic [9:0] C_LW  = 10'b1101000_101;
    localparam logic [9:0] C_SW  = 10'b0010000_110;
    localparam logic [9:0] C_BR  = 10'b0000100_111;
    localparam logic [9:0] C_PGI = 10'b0000010_111;
    localparam logic [9:0] C_PGD = 10'b0000001_111;

    localparam logic [8:0] I_LW_R3_R4  = 9'b101_011_100;
    localparam logic [8:0] I_ADD_R5_R3 = 9'b100_101_011;
    localparam logic [8:0] I_ADD_R3_R1 = 9'b100_011_001;
    localparam logic [8:0] I_ADD_R1_R2 = 9'b100_001_010;
    localparam logic [8:0] I_SW_R2_R6  = 9'b110_010_110;

    typedef struct {
        logic [8:0] instr;
        logic [7:0] pc;
        logic [9:0] ctrl;
        logic [2:0] ra;
        logic [2:0] rb;
    } vec_t;

    vec_t vecs [10];

    decode_stage #(.PCW(8), .RAW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .flush    (flush),
        .ex_hold  (ex_hold),
        .stall_o  (stall_o),
        .ex_valid (ex_valid),
        .ex_ctrl  (ex_ctrl),
        .ex_ra    (ex_ra),
        .ex_rb    (ex_rb),
        .ex_pc    (ex_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ctrl_bits();
        return {ex_ctrl.regWrite, ex_ctrl.memRead, ex_ctrl.memWrite, ex_ctrl.MemToReg,
                ex_ctrl.branch, ex_ctrl.incrementPage, ex_ctrl.decrementPage,
                3'(ex_ctrl.OP)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ex(input string name, input logic v, input logic [9:0] c,
                            input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] pc);
        chk({name, ".valid"}, 32'(ex_valid),    32'(v));
        chk({name, ".ctrl"},  32'(ctrl_bits()), 32'(c));
        chk({name, ".ra"},    32'(ex_ra),       32'(ra));
        chk({name, ".rb"},    32'(ex_rb),       32'(rb));
        chk({name, ".pc"},    32'(ex_pc),       32'(pc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] instr, input logic [7:0] pc);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic load_use(input string nm, input logic [8:0] dep, input logic [7:0] pc,
                            input logic [2:0] ra, input logic [2:0] rb);
        drive(1'b1, I_LW_R3_R4, pc);
        tick();
        check_ex({nm, "_lw"}, 1'b1, C_LW, 3'd3, 3'd4, pc);
        drive(1'b1, dep, pc + 8'd1);
        #1;
        chk({nm, "_stall"}, 32'(stall_o), 32'd1);
        tick();
        check_ex({nm, "_bubble"}, 1'b0, 10'd0, 3'd0, 3'd0, 8'd0);
        chk({nm, "_stall_clr"}, 32'(stall_o), 32'd0);
        tick();
        check_ex({nm, "_dep"}, 1'b1, C_ADD, ra, rb, pc + 8'd1);
        drive(1'b0, 9'd0, 8'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{9'b000_001_010, 8'h10, C_AND, 3'd1, 3'd2};
        vecs[1] = '{9'b001_011_100, 8'h11, C_XOR, 3'd3, 3'd4};
        vecs[2] = '{9'b010_101_110, 8'h12, C_SHL, 3'd5, 3'd6};
        vecs[3] = '{9'b011_111_000, 8'h13, C_SHR, 3'd7, 3'd0};
        vecs[4] = '{9'b100_001_010, 8'hA5, C_ADD, 3'd1, 3'd2};
        vecs[5] = '{9'b101_011_100, 8'h15, C_LW,  3'd3, 3'd4};
        vecs[6] = '{9'b110_010_110, 8'h16, C_SW,  3'd2, 3'd6};
        vecs[7] = '{9'b111_001_101, 8'h17, C_BR,  3'd1, 3'd5};
        vecs[8] = '{9'b111_111_000, 8'h18, C_PGI, 3'd7, 3'd0};
        vecs[9] = '{9'b111_111_001, 8'h19, C_PGD, 3'd7, 3'd1};

        rst_n = 1'b0;
        flush = 1'b0;
        ex_hold = 1'b0;
        drive(1'b0, 9'd0, 8'd0);
        #2;
        check_ex("reset", 1'b0, 10'd0, 3'd0, 3'd0, 8'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].pc);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'd0);
            tick();
            check_ex($sformatf("vec%0d", i), 1'b1, vecs[i].ctrl, vecs[i].ra, vecs[i].rb, vecs[i].pc);
            drive(1'b0, 9'd0, 8'd0);
            tick();
            check_ex($sformatf("vec%0d_idle", i), 1'b0, 10'd0, 3'd0, 3'd0, 8'd0);
        end

        load_use("lu_rb", I_ADD_R5_R3, 8'h20, 3'd5, 3'd3);
        load_use("lu_ra", I_ADD_R3_R1, 8'h28, 3'd3, 3'd1);

        // Independent instruction straight behind a load: no stall
        drive(1'b1, I_LW_R3_R4, 8'h30);
        tick();
        drive(1'b1, I_ADD_R1_R2, 8'h31);
        #1;
        chk("nohz_stall", 32'(stall_o), 32'd0);
        tick();
        check_ex("nohz_add", 1'b1, C_ADD, 3'd1, 3'd2, 8'h31);

        // Page op behind LW r7 must not stall
        drive(1'b1, 9'b101_111_000, 8'h32);
        tick();
        check_ex("lw_r7", 1'b1, C_LW, 3'd7, 3'd0, 8'h32);
        drive(1'b1, 9'b111_111_001, 8'h33);
        #1;
        chk("page_stall", 32'(stall_o), 32'd0);
        tick();
        check_ex("page_dec", 1'b1, C_PGD, 3'd7, 3'd1, 8'h33);

        // Flush during a load-use stall
        drive(1'b1, I_LW_R3_R4, 8'h38);
        tick();
        drive(1'b1, I_ADD_R5_R3, 8'h39);
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'(stall_o), 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 9'd0, 8'd0);
        check_ex("flush_bubble", 1'b0, 10'd0, 3'd0, 3'd0, 8'd0);

        // Flush together with hold
        drive(1'b1, I_SW_R2_R6, 8'h40);
        tick();
        check_ex("fh_sw", 1'b1, C_SW, 3'd2, 3'd6, 8'h40);
        flush = 1'b1;
        ex_hold = 1'b1;
        tick();
        flush = 1'b0;
        ex_hold = 1'b0;
        drive(1'b0, 9'd0, 8'd0);
        check_ex("fh_bubble", 1'b0, 10'd0, 3'd0, 3'd0, 8'd0);

        // Hold for three cycles with an SW in ID/EX
        drive(1'b1, I_SW_R2_R6, 8'h50);
        tick();
        drive(1'b1, I_ADD_R1_R2, 8'h51);
        ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d_stall", k), 32'(stall_o), 32'd1);
            tick();
            check_ex($sformatf("hold%0d", k), 1'b1, C_SW, 3'd2, 3'd6, 8'h50);
        end
        ex_hold = 1'b0;
        #1;
        chk("hold_rel_stall", 32'(stall_o), 32'd0);
        tick();
        check_ex("hold_rel", 1'b1, C_ADD, 3'd1, 3'd2, 8'h51);

        // Hold with a pending load-use: LW stays, then one bubble, then dependent
        drive(1'b1, I_LW_R3_R4, 8'h58);
        tick();
        drive(1'b1, I_ADD_R5_R3, 8'h59);
        ex_hold = 1'b1;
        tick();
        tick();
        check_ex("hhz_lw", 1'b1, C_LW, 3'd3, 3'd4, 8'h58);
        ex_hold = 1'b0;
        #1;
        chk("hhz_stall", 32'(stall_o), 32'd1);
        tick();
        check_ex("hhz_bubble", 1'b0, 10'd0, 3'd0, 3'd0, 8'd0);
        tick();
        check_ex("hhz_dep", 1'b1, C_ADD, 3'd5, 3'd3, 8'h59);

        // Asynchronous reset between edges during a load-use stall
        drive(1'b1, I_LW_R3_R4, 8'h60);
        tick();
        drive(1'b1, I_ADD_R5_R3, 8'h61);
        #1;
        chk("ar_stall_pre", 32'(stall_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_ex("ar_clear", 1'b0, 10'd0, 3'd0, 3'd0, 8'd0);
        chk("ar_stall", 32'(stall_o), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check_ex("ar_first", 1'b1, C_ADD, 3'd5, 3'd3, 8'h61);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
